// File: rtl/regfile_writeback_if.sv
// Write-back / register-read bundle between the datapath and the register file.
interface regfile_writeback_if #(
  parameter int DATA_W = 32
);
  logic              regwrite;
  logic [1:0]        wb_sel;
  logic [4:0]        rd;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_valid;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] imm;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic              stall;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              mem_error;

  modport master (
    output regwrite, wb_sel, rd, alu_result, mem_rdata, mem_valid, pc_plus4, imm, rs1, rs2,
    input  read_data1, read_data2, stall, wb_valid, wb_rd, wb_data, mem_error
  );

  modport slave (
    input  regwrite, wb_sel, rd, alu_result, mem_rdata, mem_valid, pc_plus4, imm, rs1, rs2,
    output read_data1, read_data2, stall, wb_valid, wb_rd, wb_data, mem_error
  );
endinterface

// File: rtl/regfile_writeback.sv
// 32-entry register file with write-back source select, read bypass,
// a late-load wait FSM with timeout, and a registered commit trace.
module regfile_writeback #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst_n,
  regfile_writeback_if.slave bus
);
  typedef enum logic {IDLE, WAIT_MEM} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [7:0]        cnt;
  logic [4:0]        pend_rd;
  logic [DATA_W-1:0] regs [32];

  logic              commit;
  logic [4:0]        commit_rd;
  logic [DATA_W-1:0] commit_data;
  logic [DATA_W-1:0] sel_data;
  logic              stall;

  logic              trace_valid;
  logic [4:0]        trace_rd;
  logic [DATA_W-1:0] trace_data;
  logic              err;

  always_comb begin
    case (bus.wb_sel)
      2'b00:   sel_data = bus.alu_result;
      2'b01:   sel_data = bus.mem_rdata;
      2'b10:   sel_data = bus.pc_plus4;
      default: sel_data = bus.imm;
    endcase
  end

  // In WAIT_MEM only mem_valid/mem_rdata matter; the latched rd is the target.
  always_comb begin
    commit      = 1'b0;
    commit_rd   = bus.rd;
    commit_data = sel_data;
    stall       = 1'b0;
    if (state == IDLE) begin
      if (bus.regwrite) begin
        if (bus.wb_sel != 2'b01 || bus.mem_valid) commit = 1'b1;
        else                                     stall  = 1'b1;
      end
    end else begin
      commit_rd   = pend_rd;
      commit_data = bus.mem_rdata;
      if (bus.mem_valid) commit = 1'b1;
      else               stall  = 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [4:0] idx);
    if (idx == 5'd0)                        return '0;
    else if (commit && commit_rd == idx)    return commit_data;
    else                                    return regs[idx];
  endfunction

  assign bus.read_data1 = read_port(bus.rs1);
  assign bus.read_data2 = read_port(bus.rs2);
  assign bus.stall      = stall;
  assign bus.wb_valid   = trace_valid;
  assign bus.wb_rd      = trace_rd;
  assign bus.wb_data    = trace_data;
  assign bus.mem_error  = err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pend_rd     <= '0;
      trace_valid <= 1'b0;
      trace_rd    <= '0;
      trace_data  <= '0;
      err         <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) regs[i[4:0]] <= '0;
    end else begin
      trace_valid <= commit;
      if (commit) begin
        trace_rd   <= commit_rd;
        trace_data <= commit_data;
        if (commit_rd != 5'd0) regs[commit_rd] <= commit_data;
      end
      case (state)
        IDLE: begin
          if (bus.regwrite && bus.wb_sel == 2'b01 && !bus.mem_valid) begin
            state   <= WAIT_MEM;
            pend_rd <= bus.rd;
            cnt     <= '0;
          end
        end
        WAIT_MEM: begin
          if (bus.mem_valid) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            err   <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench: directed vector table, hand-written load/timeout/reset
// sequences, then randomized traffic against a behavioural register-file model.
module tb_regfile_writeback;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_writeback_if #(.DATA_W(DATA_W)) bus ();

  regfile_writeback #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  bit          m_wait;
  int          m_waited;
  logic [4:0]  m_rd;
  bit          m_err;
  bit          m_tv;
  logic [4:0]  m_trd;
  logic [31:0] m_tdata;

  // Observations from the most recent cycle
  logic        obs_stall;
  logic        obs_wbv;
  logic [31:0] obs_rd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_wait = 0; m_waited = 0; m_rd = '0; m_err = 0;
    m_tv = 0; m_trd = '0; m_tdata = '0;
  endtask

  task automatic set_in(input bit rw, input logic [1:0] sel, input logic [4:0] rd,
                        input logic [31:0] val, input bit mv,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    bus.regwrite   = rw;
    bus.wb_sel     = sel;
    bus.rd         = rd;
    bus.alu_result = (sel == 2'b00) ? val : val ^ 32'h0F0F_0001;
    bus.mem_rdata  = (sel == 2'b01) ? val : val ^ 32'h00FF_0002;
    bus.pc_plus4   = (sel == 2'b10) ? val : val ^ 32'h3C3C_0003;
    bus.imm        = (sel == 2'b11) ? val : val ^ 32'h5A5A_0004;
    bus.mem_valid  = mv;
    bus.rs1        = rs1;
    bus.rs2        = rs2;
  endtask

  function automatic logic [31:0] src_val();
    case (bus.wb_sel)
      2'b00:   return bus.alu_result;
      2'b01:   return bus.mem_rdata;
      2'b10:   return bus.pc_plus4;
      default: return bus.imm;
    endcase
  endfunction

  // One clock: check outputs at negedge against the model, then advance the model.
  task automatic cycle(input string tag);
    bit          exp_stall, do_wr;
    logic [4:0]  wr;
    logic [31:0] wd, e1, e2;
    bit          rw, mv;
    logic [1:0]  sel;
    logic [4:0]  rd;
    @(negedge clk);
    rw = bus.regwrite; mv = bus.mem_valid; sel = bus.wb_sel; rd = bus.rd;
    exp_stall = 0; do_wr = 0; wr = rd; wd = src_val();
    if (!m_wait) begin
      if (rw) begin
        if (sel == 2'b01 && !mv) exp_stall = 1;
        else                     do_wr = 1;
      end
    end else begin
      wr = m_rd; wd = bus.mem_rdata;
      if (mv) do_wr = 1; else exp_stall = 1;
    end
    e1 = (bus.rs1 == 0) ? 32'h0 : (do_wr && wr == bus.rs1) ? wd : m_regs[bus.rs1];
    e2 = (bus.rs2 == 0) ? 32'h0 : (do_wr && wr == bus.rs2) ? wd : m_regs[bus.rs2];
    chk({tag, ".stall"}, {31'b0, bus.stall}, {31'b0, exp_stall});
    chk({tag, ".rd1"}, bus.read_data1, e1);
    chk({tag, ".rd2"}, bus.read_data2, e2);
    chk({tag, ".wb_valid"}, {31'b0, bus.wb_valid}, {31'b0, m_tv});
    if (m_tv) begin
      chk({tag, ".wb_rd"}, {27'b0, bus.wb_rd}, {27'b0, m_trd});
      chk({tag, ".wb_data"}, bus.wb_data, m_tdata);
    end
    chk({tag, ".mem_error"}, {31'b0, bus.mem_error}, {31'b0, m_err});
    obs_stall = bus.stall; obs_wbv = bus.wb_valid; obs_rd1 = bus.read_data1;
    @(posedge clk);
    m_tv = do_wr;
    if (do_wr) begin
      m_trd = wr; m_tdata = wd;
      if (wr != 0) m_regs[wr] = wd;
    end
    if (!m_wait) begin
      if (rw && sel == 2'b01 && !mv) begin
        m_wait = 1; m_rd = rd; m_waited = 0;
      end
    end else if (mv) begin
      m_wait = 0;
    end else begin
      m_waited++;
      if (m_waited == TIMEOUT) begin
        m_wait = 0; m_err = 1;
      end
    end
    #1;
  endtask

  typedef struct {
    bit          rw;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [31:0] val;
    bit          mv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    bit          exp_stall;
    logic [31:0] exp_rd1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int cnt_stall, cnt_wbv, guard;

    vecs[0] = '{1, 2'b00, 5'd5, 32'h0000_00AA, 0, 5'd5, 5'd0, 0, 32'h0000_00AA};
    vecs[1] = '{1, 2'b11, 5'd0, 32'hDEAD_BEEF, 0, 5'd0, 5'd5, 0, 32'h0};
    vecs[2] = '{1, 2'b10, 5'd6, 32'h0000_0100, 0, 5'd5, 5'd6, 0, 32'h0000_00AA};
    vecs[3] = '{1, 2'b01, 5'd8, 32'h0000_CAFE, 1, 5'd8, 5'd6, 0, 32'h0000_CAFE};
    vecs[4] = '{0, 2'b00, 5'd9, 32'h0000_0055, 1, 5'd9, 5'd8, 0, 32'h0};
    vecs[5] = '{1, 2'b00, 5'd5, 32'h0000_0011, 0, 5'd5, 5'd0, 0, 32'h0000_0011};

    set_in(0, 2'b00, 0, 0, 0, 0, 0);
    model_reset();
    #12 rst_n = 1'b1;
    #1;

    // Reset state: every index reads 0
    for (int i = 0; i < 32; i += 2) begin
      set_in(0, 2'b00, 0, 0, 0, 5'(i), 5'(i + 1));
      cycle("reset_read");
    end

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      set_in(vecs[i].rw, vecs[i].sel, vecs[i].rd, vecs[i].val, vecs[i].mv, vecs[i].rs1, vecs[i].rs2);
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_stall", i), {31'b0, obs_stall}, {31'b0, vecs[i].exp_stall});
      chk($sformatf("vec%0d.tbl_rd1", i), obs_rd1, vecs[i].exp_rd1);
    end
    set_in(0, 2'b00, 0, 0, 0, 5'd5, 5'd0);
    cycle("vec_tail");

    // Late load to x7: mem_valid low 3 cycles, then data; WAIT inputs must be ignored
    cnt_stall = 0; cnt_wbv = 0;
    set_in(1, 2'b01, 5'd7, 32'h0, 0, 5'd7, 5'd3);
    cycle("load7");
    cnt_stall += obs_stall; cnt_wbv += obs_wbv;
    for (int k = 0; k < 2; k++) begin
      set_in(1, 2'b00, 5'd3, 32'h0BAD_0BAD, 0, 5'd7, 5'd3);
      cycle("load7_wait");
      cnt_stall += obs_stall; cnt_wbv += obs_wbv;
    end
    set_in(1, 2'b00, 5'd3, 32'h1234_5678, 1, 5'd7, 5'd3);
    bus.mem_rdata = 32'h1234_5678;
    bus.alu_result = 32'h0BAD_0BAD;
    cycle("load7_done");
    chk("load7.done_stall", {31'b0, obs_stall}, 32'h0);
    chk("load7.bypass", obs_rd1, 32'h1234_5678);
    cnt_stall += obs_stall; cnt_wbv += obs_wbv;
    set_in(0, 2'b00, 0, 0, 0, 5'd7, 5'd3);
    cycle("load7_after");
    cnt_wbv += obs_wbv;
    chk("load7.stored", obs_rd1, 32'h1234_5678);
    cycle("load7_after2");
    cnt_wbv += obs_wbv;
    chk("load7.stall_cycles", cnt_stall, 3);
    chk("load7.wb_pulses", cnt_wbv, 1);

    // Timeout: mem_valid never arrives
    cnt_stall = 0; guard = 0;
    set_in(1, 2'b01, 5'd9, 32'h0, 0, 5'd9, 5'd0);
    cycle("tmo_start");
    cnt_stall += obs_stall;
    set_in(0, 2'b00, 0, 32'h0, 0, 5'd9, 5'd0);
    while (obs_stall && guard < 40) begin
      cycle("tmo_wait");
      cnt_stall += obs_stall;
      guard++;
    end
    chk("tmo.bounded", {31'b0, obs_stall}, 32'h0);
    chk("tmo.stall_cycles", cnt_stall, TIMEOUT + 1);
    chk("tmo.no_write", obs_rd1, 32'h0);
    cycle("tmo_sticky");
    chk("tmo.err_sticky", {31'b0, bus.mem_error}, 32'h1);

    // Reset in the middle of WAIT_MEM
    set_in(1, 2'b01, 5'd12, 32'h0, 0, 5'd12, 5'd0);
    cycle("rstw_start");
    set_in(0, 2'b00, 0, 32'h7777_7777, 0, 5'd12, 5'd0);
    cycle("rstw_wait");
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rstw.stall_in_reset", {31'b0, bus.stall}, 32'h0);
    chk("rstw.err_in_reset", {31'b0, bus.mem_error}, 32'h0);
    #1 rst_n = 1'b1;
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    cycle("rstw_after");
    chk("rstw.target_zero", obs_rd1, 32'h0);
    set_in(0, 2'b00, 0, 0, 0, 5'd12, 5'd0);
    cycle("rstw_after2");

    // Randomized traffic; mem_valid is sparse in some phases to reach timeouts
    for (int n = 0; n < 400; n++) begin
      int unsigned mv_pct;
      mv_pct = (n < 200) ? 40 : 4;
      set_in($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
             $urandom, $urandom_range(0, 99) < mv_pct, 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)));
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule
